// File: rtl/apuf_ctrl_pkg.sv
// apuf_ctrl_pkg: shared types and helpers for the arbiter-PUF vote controller.
//   state_e : controller FSM states
//   rotl    : left rotation of the low `width` bits of a value (width < 64)
//   vote_w  : counter width needed to count 0..evals
`timescale 1ns/1ps
package apuf_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_FIRE  = 3'd2,
    ST_RELAX = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Widest challenge the rotation helper supports is ROT_MAX_W-1 bits.
  localparam int unsigned ROT_MAX_W = 64;

  // Rotate the low `width` bits of val left by sh (sh < width); upper bits return 0.
  function automatic logic [63:0] rotl(input logic [63:0] val,
                                       input int unsigned width,
                                       input int unsigned sh);
    logic [63:0] mask;
    logic [63:0] v;
    mask = (64'd1 << width) - 64'd1;
    v    = val & mask;
    return ((v << sh) | (v >> (width - sh))) & mask;
  endfunction

  function automatic int unsigned vote_w(input int unsigned evals);
    return $clog2(evals + 1);
  endfunction

endpackage

// File: rtl/puf_vote_acc.sv
// puf_vote_acc: per-bank vote accumulator, one counter per response bit.
//   clk, rst_n : clock, async active-low reset
//   clr        : zero all counters (new challenge)
//   sample     : add raw bits into counters
//   raw        : raw arbiter outputs of this bank
//   voted      : majority of the accumulated samples
//   unanimous  : 1 where every sample agreed (count 0 or EVALS)
`timescale 1ns/1ps
module puf_vote_acc
  import apuf_ctrl_pkg::*;
#(
  parameter int unsigned RW    = 16,
  parameter int unsigned EVALS = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          sample,
  input  logic [RW-1:0] raw,
  output logic [RW-1:0] voted,
  output logic [RW-1:0] unanimous
);

  localparam int unsigned   VW   = vote_w(EVALS);
  localparam logic [VW-1:0] HALF = VW'(EVALS / 2);
  localparam logic [VW-1:0] FULL = VW'(EVALS);

  logic [VW-1:0] cnt_q [RW];
  logic [VW-1:0] cnt_d [RW];

  // Next counter values plus majority/unanimity decode of the current counts.
  always_comb begin
    for (int i = 0; i < RW; i++) begin
      if (clr) begin
        cnt_d[i] = {VW{1'b0}};
      end else if (sample) begin
        cnt_d[i] = cnt_q[i] + VW'(raw[i]);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      voted[i]     = (cnt_q[i] > HALF);
      unanimous[i] = (cnt_q[i] == {VW{1'b0}}) || (cnt_q[i] == FULL);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RW; i++) begin
        cnt_q[i] <= {VW{1'b0}};
      end
    end else begin
      for (int i = 0; i < RW; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: rtl/apuf_vote_ctrl.sv
// apuf_vote_ctrl: sequenced multi-bank arbiter-PUF combiner.
//   in_valid/in_ready/in_challenge      : challenge handshake (accepted only in IDLE)
//   puf_pulse                           : shared race pulse, SETTLE high / SETTLE low per eval
//   puf_challenge                       : bank b gets in_challenge rotated left by (b*ROT)%CW
//   puf_raw                             : raw arbiter bits, sampled at end of each pulse-high phase
//   out_valid/out_ready                 : response handshake, held in DONE until accepted
//   out_response                        : XOR over banks of majority-voted bits
//   out_unstable                        : OR over banks of non-unanimous bits
// CW must be below 64 (rotation helper width).
`timescale 1ns/1ps
module apuf_vote_ctrl
  import apuf_ctrl_pkg::*;
#(
  parameter int unsigned CW     = 16,
  parameter int unsigned RW     = 16,
  parameter int unsigned BANKS  = 2,
  parameter int unsigned ROT    = 8,
  parameter int unsigned EVALS  = 5,
  parameter int unsigned SETTLE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CW-1:0]       in_challenge,
  output logic                puf_pulse,
  output logic [BANKS*CW-1:0] puf_challenge,
  input  logic [BANKS*RW-1:0] puf_raw,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RW-1:0]       out_response,
  output logic [RW-1:0]       out_unstable
);

  localparam int unsigned   EW         = vote_w(EVALS);
  localparam int unsigned   PW         = $clog2(SETTLE + 1);
  localparam logic [EW-1:0] EVAL_LAST  = EW'(EVALS - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(SETTLE - 1);

  state_e               state_q, state_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic [EW-1:0]        eval_q, eval_d;
  logic [BANKS*CW-1:0]  chal_q, chal_d;
  logic [RW-1:0]        resp_q, resp_d;
  logic [RW-1:0]        unst_q, unst_d;
  logic                 pulse_q, pulse_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;

  logic                 clr_s;
  logic                 sample_s;
  logic [BANKS*CW-1:0]  rot_chal_s;
  logic [BANKS-1:0][RW-1:0] voted_s;
  logic [BANKS-1:0][RW-1:0] unan_s;
  logic [RW-1:0]        fold_resp_s;
  logic [RW-1:0]        fold_unst_s;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    localparam int unsigned SH = (b * ROT) % CW;
    logic [63:0] rot_full_s;
    logic        unused_rot_hi_s;

    assign rot_full_s                = rotl(64'(in_challenge), CW, SH);
    assign rot_chal_s[b*CW +: CW]    = rot_full_s[CW-1:0];
    assign unused_rot_hi_s           = ^rot_full_s[63:CW];

    puf_vote_acc #(
      .RW    (RW),
      .EVALS (EVALS)
    ) u_acc (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr_s),
      .sample    (sample_s),
      .raw       (puf_raw[b*RW +: RW]),
      .voted     (voted_s[b]),
      .unanimous (unan_s[b])
    );
  end

  // Fold the voted banks into a single response and instability mask.
  always_comb begin
    fold_resp_s = {RW{1'b0}};
    fold_unst_s = {RW{1'b0}};
    for (int b = 0; b < BANKS; b++) begin
      fold_resp_s = fold_resp_s ^ voted_s[b];
      fold_unst_s = fold_unst_s | ~unan_s[b];
    end
  end

  // FSM, phase/eval counters and output-register next-state logic.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    eval_d   = eval_q;
    chal_d   = chal_q;
    resp_d   = resp_q;
    unst_d   = unst_q;
    clr_s    = 1'b0;
    sample_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          chal_d  = rot_chal_s;
          eval_d  = {EW{1'b0}};
          phase_d = {PW{1'b0}};
          clr_s   = 1'b1;
          state_d = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        phase_d = {PW{1'b0}};
        state_d = ST_FIRE;
      end
      ST_FIRE: begin
        if (phase_q == PHASE_LAST) begin
          phase_d  = {PW{1'b0}};
          sample_s = 1'b1;
          state_d  = ST_RELAX;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      ST_RELAX: begin
        if (phase_q == PHASE_LAST) begin
          phase_d = {PW{1'b0}};
          eval_d  = eval_q + EW'(1);
          if (eval_q == EVAL_LAST) begin
            resp_d  = fold_resp_s;
            unst_d  = fold_unst_s;
            state_d = ST_DONE;
          end else begin
            state_d = ST_FIRE;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Outputs are registered from the next state so they line up with it.
    pulse_d     = (state_d == ST_FIRE);
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= {PW{1'b0}};
      eval_q      <= {EW{1'b0}};
      chal_q      <= {(BANKS*CW){1'b0}};
      resp_q      <= {RW{1'b0}};
      unst_q      <= {RW{1'b0}};
      pulse_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      eval_q      <= eval_d;
      chal_q      <= chal_d;
      resp_q      <= resp_d;
      unst_q      <= unst_d;
      pulse_q     <= pulse_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign puf_pulse     = pulse_q;
  assign puf_challenge = chal_q;
  assign out_valid     = out_valid_q;
  assign out_response  = resp_q;
  assign out_unstable  = unst_q;

endmodule

// File: tb/tb_apuf_vote_ctrl.sv
`timescale 1ns/1ps
module tb_apuf_vote_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_challenge = 16'h0000;
  logic        puf_pulse;
  logic [31:0] puf_challenge;
  logic [31:0] puf_raw = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_response;
  logic [15:0] out_unstable;

  logic        p_in_valid = 1'b0;
  logic        p_in_ready;
  logic [7:0]  p_in_challenge = 8'h00;
  logic        p_puf_pulse;
  logic [23:0] p_puf_challenge;
  logic [23:0] p_puf_raw = 24'h0;
  logic        p_out_valid;
  logic        p_out_ready = 1'b0;
  logic [7:0]  p_out_response;
  logic [7:0]  p_out_unstable;

  always #5 clk = ~clk;

  apuf_vote_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_challenge(in_challenge), .puf_pulse(puf_pulse), .puf_challenge(puf_challenge),
    .puf_raw(puf_raw), .out_valid(out_valid), .out_ready(out_ready),
    .out_response(out_response), .out_unstable(out_unstable)
  );

  apuf_vote_ctrl #(.CW(8), .RW(8), .BANKS(3), .ROT(2), .EVALS(1), .SETTLE(1)) dut_p (
    .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .in_challenge(p_in_challenge), .puf_pulse(p_puf_pulse), .puf_challenge(p_puf_challenge),
    .puf_raw(p_puf_raw), .out_valid(p_out_valid), .out_ready(p_out_ready),
    .out_response(p_out_response), .out_unstable(p_out_unstable)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected {response, unstable}
  typedef struct packed {logic [15:0] resp; logic [15:0] unst;} exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_response actual=0x%0h expected=none", out_response);
      end else begin
        mon_e = sb_q.pop_front();
        check("out_response", 64'(out_response), 64'(mon_e.resp));
        check("out_unstable", 64'(out_unstable), 64'(mon_e.unst));
      end
    end
  end

  // Raw-bit driver: one raw word per evaluation, advanced on each pulse fall
  logic [15:0] raw0 [5];
  logic [15:0] raw1 [5];
  int   eval_idx = 0;
  logic pulse_prev = 1'b0;

  always @(negedge clk) begin
    if (in_valid && in_ready) eval_idx = 0;
    else if (pulse_prev && !puf_pulse) eval_idx = eval_idx + 1;
    pulse_prev = puf_pulse;
    if (eval_idx < 5) puf_raw = {raw1[eval_idx], raw0[eval_idx]};
    else puf_raw = 32'h0;
  end

  task automatic set_raw(input logic [15:0] r0, input logic [15:0] r1);
    for (int i = 0; i < 5; i++) begin
      raw0[i] = r0;
      raw1[i] = r1;
    end
  endtask

  int pulse_log [0:255];

  // Issue one challenge, check latency/challenge/pulse shape, optionally stall output
  task automatic run_txn(input logic [15:0] c, input logic [15:0] er, input logic [15:0] eu,
                         input int hold, input bit chk_shape);
    int n;
    int lat;
    int bad;
    bit got;
    bit stable;
    logic [31:0] exp_chal;
    logic        exp_pulse;
    exp_chal = {c[7:0], c[15:8], c};
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_challenge = c;
    sb_q.push_back('{resp: er, unst: eu});
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("puf_challenge", 64'(puf_challenge), 64'(exp_chal));
      pulse_log[lat] = int'(puf_pulse);
      if (out_valid) got = 1'b1;
    end
    check("out_valid_latency", 64'(lat), 64'd42);
    if (chk_shape) begin
      bad = 0;
      for (int l = 1; l <= 42; l++) begin
        exp_pulse = (l >= 2 && l <= 41 && ((l - 2) % 8) < 4);
        if (pulse_log[l] != int'(exp_pulse)) bad++;
      end
      check("pulse_shape_errors", 64'(bad), 64'd0);
    end
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        in_valid = i[0];
        in_challenge = 16'hA5A5 ^ 16'(i);
        @(negedge clk);
        if (!(out_valid && !in_ready && out_response == er && out_unstable == eu &&
              puf_challenge == exp_chal)) stable = 1'b0;
      end
      check("backpressure_hold", 64'(stable), 64'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("in_ready_after_accept", 64'(in_ready), 64'd1);
    check("out_valid_after_accept", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lat;
    int rises;
    logic prev;
    set_raw(16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_puf_pulse", 64'(puf_pulse), 64'd0);
    check("rst_puf_challenge", 64'(puf_challenge), 64'd0);
    check("rst_out_response", 64'(out_response), 64'd0);
    check("rst_out_unstable", 64'(out_unstable), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Constant fold, rotation, pulse shape
    set_raw(16'h00FF, 16'h0F0F);
    run_txn(16'h1234, 16'h0FF0, 16'h0000, 0, 1'b1);

    // Majority 3 of 5 on bank0 bit0
    set_raw(16'h0000, 16'h0000);
    raw0[0] = 16'h0001; raw0[2] = 16'h0001; raw0[4] = 16'h0001;
    run_txn(16'h0001, 16'h0001, 16'h0001, 0, 1'b0);

    // Minority 2 of 5
    set_raw(16'h0000, 16'h0000);
    raw0[1] = 16'h0001; raw0[3] = 16'h0001;
    run_txn(16'hCAFE, 16'h0000, 16'h0001, 0, 1'b0);

    // Output backpressure, then a clean follow-up transaction
    set_raw(16'hF000, 16'h000F);
    run_txn(16'h55AA, 16'hF00F, 16'h0000, 10, 1'b0);
    set_raw(16'hAAAA, 16'h5555);
    run_txn(16'h0F0F, 16'hFFFF, 16'h0000, 0, 1'b0);

    // Reset during the third evaluation's FIRE phase
    set_raw(16'h00FF, 16'hFFFF);
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    in_valid = 1'b1;
    in_challenge = 16'hBEEF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rises = 0; prev = 1'b0; n = 0;
    while (rises < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (puf_pulse && !prev) rises++;
      prev = puf_pulse;
    end
    check("pulse_before_reset", 64'(puf_pulse), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_puf_pulse", 64'(puf_pulse), 64'd0);
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_puf_challenge", 64'(puf_challenge), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_raw(16'hFFFF, 16'h0000);
    run_txn(16'h1357, 16'hFFFF, 16'h0000, 0, 1'b0);

    // Parametrised instance: CW=RW=8, BANKS=3, ROT=2, EVALS=1, SETTLE=1
    p_puf_raw = {8'h0F, 8'h55, 8'h3C};
    n = 0;
    while (!p_in_ready && n < 100) begin @(posedge clk); #1; n++; end
    p_in_valid = 1'b1;
    p_in_challenge = 8'h81;
    @(posedge clk); #1;
    p_in_valid = 1'b0;
    lat = 0;
    while (!p_out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("p_puf_challenge", 64'(p_puf_challenge), 64'h18_06_81);
    end
    check("p_out_valid_latency", 64'(lat), 64'd4);
    check("p_out_response", 64'(p_out_response), 64'h66);
    check("p_out_unstable", 64'(p_out_unstable), 64'h00);
    @(posedge clk); #1;
    p_out_ready = 1'b1;
    @(posedge clk); #1;
    p_out_ready = 1'b0;
    @(negedge clk);
    check("p_in_ready_after", 64'(p_in_ready), 64'd1);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
